// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core: ALU control encodings,
// forward-select codes and the forwarding match rule.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_ADDU = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_SUBU = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_BEQ  = 4'b1001,
    ALU_BNE  = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // A later stage supplies the operand only if it writes a real register ($0 is hardwired).
  function automatic logic reg_match(input logic we, input logic [4:0] wr, input logic [4:0] idx);
    return we && (wr != 5'd0) && (wr == idx);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between decode / later pipeline stages and the ID/EX register.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface id_ex_stage_if;
  import mips_pkg::*;

  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [31:0] id_RD1;
  logic [31:0] id_RD2;
  logic [31:0] id_SignImm;
  logic [4:0]  id_sa;
  logic [3:0]  id_aluCtrl;
  logic        id_ALUSrc;
  logic        id_RegDst;
  logic        id_RegWrite;
  logic        id_MemRead;
  logic        id_MemWrite;
  logic        id_MemtoReg;
  logic        flush;
  logic        exmem_RegWrite;
  logic [4:0]  exmem_WriteReg;
  logic [31:0] exmem_ALUResult;
  logic        memwb_RegWrite;
  logic [4:0]  memwb_WriteReg;
  logic [31:0] memwb_Result;

  logic        stall;
  logic [31:0] SrcA;
  logic [31:0] RD2;
  logic [31:0] SignImm;
  logic [4:0]  sa;
  logic [3:0]  aluCtrl;
  logic        ALUSrc;
  logic        ex_valid;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        ex_RegWrite;
  logic        ex_MemRead;
  logic        ex_MemWrite;
  logic        ex_MemtoReg;
  fwd_sel_e    fwd_sel_a;
  fwd_sel_e    fwd_sel_b;

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_RD1, id_RD2,
           id_SignImm, id_sa, id_aluCtrl, id_ALUSrc, id_RegDst, id_RegWrite,
           id_MemRead, id_MemWrite, id_MemtoReg, flush,
           exmem_RegWrite, exmem_WriteReg, exmem_ALUResult,
           memwb_RegWrite, memwb_WriteReg, memwb_Result,
    output stall, SrcA, RD2, SignImm, sa, aluCtrl, ALUSrc, ex_valid, WriteReg,
           WriteData, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
           fwd_sel_a, fwd_sel_b
  );

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_RD1, id_RD2,
           id_SignImm, id_sa, id_aluCtrl, id_ALUSrc, id_RegDst, id_RegWrite,
           id_MemRead, id_MemWrite, id_MemtoReg, flush,
           exmem_RegWrite, exmem_WriteReg, exmem_ALUResult,
           memwb_RegWrite, memwb_WriteReg, memwb_Result,
    input  stall, SrcA, RD2, SignImm, sa, aluCtrl, ALUSrc, ex_valid, WriteReg,
           WriteData, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
           fwd_sel_a, fwd_sel_b
  );

endinterface

// File: rtl/forward_unit.sv
// Per-operand bypass mux: EX/MEM beats MEM/WB, which beats the register file value.
module forward_unit
  import mips_pkg::*;
(
  input  logic [4:0]  idx,
  input  logic [31:0] rf_data,
  input  logic        exmem_we,
  input  logic [4:0]  exmem_wr,
  input  logic [31:0] exmem_data,
  input  logic        memwb_we,
  input  logic [4:0]  memwb_wr,
  input  logic [31:0] memwb_data,
  output fwd_sel_e    sel,
  output logic [31:0] data
);

  // Pick the youngest in-flight producer of this register.
  always_comb begin
    sel = FWD_NONE;
    if (reg_match(exmem_we, exmem_wr, idx)) begin
      sel = FWD_EXMEM;
    end else if (reg_match(memwb_we, memwb_wr, idx)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_NONE;
    end
  end

  // Steer the data for the chosen source.
  always_comb begin
    data = rf_data;
    case (sel)
      FWD_EXMEM: data = exmem_data;
      FWD_MEMWB: data = memwb_data;
      FWD_NONE:  data = rf_data;
      default:   data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall detection.
module id_ex_stage
  import mips_pkg::*;
(
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  logic        valid_r;
  logic [4:0]  rs_r;
  logic [4:0]  rt_r;
  logic [4:0]  write_reg_r;
  logic [31:0] rd1_r;
  logic [31:0] rd2_r;
  logic [31:0] sign_imm_r;
  logic [4:0]  sa_r;
  logic [3:0]  alu_ctrl_r;
  logic        alu_src_r;
  logic        reg_write_r;
  logic        mem_read_r;
  logic        mem_write_r;
  logic        mem_to_reg_r;

  logic        rs_dep_s;
  logic        rt_dep_s;
  logic        load_use_s;
  logic [31:0] src_a_s;
  logic [31:0] src_b_s;

  // A load's destination is its rt; decode must wait if it reads that register now.
  assign rs_dep_s   = bus.id_uses_rs && (bus.id_rs == rt_r);
  assign rt_dep_s   = bus.id_uses_rt && (bus.id_rt == rt_r);
  assign load_use_s = valid_r && mem_read_r && (rt_r != 5'd0) && bus.id_valid
                      && (rs_dep_s || rt_dep_s);
  assign bus.stall  = load_use_s && !bus.flush;

  // Pipeline register: reset, flush and load-use all load a bubble.
  always_ff @(posedge clk) begin
    if (rst || bus.flush || load_use_s) begin
      valid_r      <= 1'b0;
      rs_r         <= 5'd0;
      rt_r         <= 5'd0;
      write_reg_r  <= 5'd0;
      rd1_r        <= 32'd0;
      rd2_r        <= 32'd0;
      sign_imm_r   <= 32'd0;
      sa_r         <= 5'd0;
      alu_ctrl_r   <= 4'b0000;
      alu_src_r    <= 1'b0;
      reg_write_r  <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
    end else begin
      valid_r      <= bus.id_valid;
      rs_r         <= bus.id_rs;
      rt_r         <= bus.id_rt;
      write_reg_r  <= bus.id_RegDst ? bus.id_rd : bus.id_rt;
      rd1_r        <= bus.id_RD1;
      rd2_r        <= bus.id_RD2;
      sign_imm_r   <= bus.id_SignImm;
      sa_r         <= bus.id_sa;
      alu_ctrl_r   <= bus.id_aluCtrl;
      alu_src_r    <= bus.id_ALUSrc;
      reg_write_r  <= bus.id_RegWrite;
      mem_read_r   <= bus.id_MemRead;
      mem_write_r  <= bus.id_MemWrite;
      mem_to_reg_r <= bus.id_MemtoReg;
    end
  end

  forward_unit u_fwd_rs (
    .idx        (rs_r),
    .rf_data    (rd1_r),
    .exmem_we   (bus.exmem_RegWrite),
    .exmem_wr   (bus.exmem_WriteReg),
    .exmem_data (bus.exmem_ALUResult),
    .memwb_we   (bus.memwb_RegWrite),
    .memwb_wr   (bus.memwb_WriteReg),
    .memwb_data (bus.memwb_Result),
    .sel        (bus.fwd_sel_a),
    .data       (src_a_s)
  );

  forward_unit u_fwd_rt (
    .idx        (rt_r),
    .rf_data    (rd2_r),
    .exmem_we   (bus.exmem_RegWrite),
    .exmem_wr   (bus.exmem_WriteReg),
    .exmem_data (bus.exmem_ALUResult),
    .memwb_we   (bus.memwb_RegWrite),
    .memwb_wr   (bus.memwb_WriteReg),
    .memwb_data (bus.memwb_Result),
    .sel        (bus.fwd_sel_b),
    .data       (src_b_s)
  );

  assign bus.SrcA        = src_a_s;
  assign bus.RD2         = src_b_s;
  assign bus.WriteData   = src_b_s;
  assign bus.SignImm     = sign_imm_r;
  assign bus.sa          = sa_r;
  assign bus.aluCtrl     = alu_ctrl_r;
  assign bus.ALUSrc      = alu_src_r;
  assign bus.ex_valid    = valid_r;
  assign bus.WriteReg    = write_reg_r;
  assign bus.ex_RegWrite = reg_write_r;
  assign bus.ex_MemRead  = mem_read_r;
  assign bus.ex_MemWrite = mem_write_r;
  assign bus.ex_MemtoReg = mem_to_reg_r;

endmodule
